// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: state encoding and condition-code constants shared by branch control, condition FF and decoder
package branch_ctrl_pkg;
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_T3   = 5'b00010,
    S_T4   = 5'b00100,
    S_T5   = 5'b01000,
    S_T6   = 5'b10000
  } state_t;
  localparam logic [1:0] C2_ZERO    = 2'b00;
  localparam logic [1:0] C2_NONZERO = 2'b01;
  localparam logic [1:0] C2_POS     = 2'b10;
  localparam logic [1:0] C2_NEG     = 2'b11;
endpackage

// File: rtl/branch_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (!clr_n) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: sequences T3..T6 of a conditional branch around the condition flip-flop
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [1:0]       c2_in,
  input  logic             con_q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       ir_c2,
  output logic             gra,
  output logic             r_out,
  output logic             con_enable,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlo_out,
  output logic             pc_in,
  output logic             taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  state_t state, state_n;
  always_comb
    state_n = (state == S_IDLE) ? (start ? S_T3 : S_IDLE) :
              (state == S_T3)   ? S_T4 :
              (state == S_T4)   ? S_T5 :
              (state == S_T5)   ? S_T6 : S_IDLE;
  // strobes register the next-state decode so they line up exactly with the state
  always_ff @(posedge clk)
    if (!clr_n) begin
      state      <= S_IDLE;
      ir_c2      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gra        <= 1'b0;
      r_out      <= 1'b0;
      con_enable <= 1'b0;
      pc_out     <= 1'b0;
      y_in       <= 1'b0;
      c_out      <= 1'b0;
      alu_add    <= 1'b0;
      z_in       <= 1'b0;
      zlo_out    <= 1'b0;
      pc_in      <= 1'b0;
      taken      <= 1'b0;
    end else begin
      state      <= state_n;
      if (state == S_IDLE && start) ir_c2 <= c2_in;
      busy       <= state_n != S_IDLE;
      gra        <= state_n == S_T3;
      r_out      <= state_n == S_T3;
      con_enable <= state_n == S_T3;
      pc_out     <= state_n == S_T4;
      y_in       <= state_n == S_T4;
      c_out      <= state_n == S_T5;
      alu_add    <= state_n == S_T5;
      z_in       <= state_n == S_T5;
      zlo_out    <= state_n == S_T6;
      done       <= state_n == S_T6;
      pc_in      <= state_n == S_T6 && con_q;
      if (state == S_T6) taken <= pc_in;
    end
  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk  (clk),
    .clr_n(clr_n),
    .inc  (state == S_T6),
    .cnt  (branch_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk  (clk),
    .clr_n(clr_n),
    .inc  (state == S_T6 && pc_in),
    .cnt  (taken_cnt)
  );
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed checks of branch_ctrl against a behavioural condition flip-flop
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;
  logic clk = 0, clr_n = 0, start = 0, con_q = 0;
  logic [1:0] c2_in = '0;
  logic busy, done, gra, r_out, con_enable, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in, taken;
  logic [1:0] ir_c2;
  logic [15:0] branch_cnt, taken_cnt;
  logic [31:0] bus = '0;
  int checks = 0, errors = 0;
  logic [46:0] all_out;
  assign all_out = {busy, done, ir_c2, gra, r_out, con_enable, pc_out, y_in, c_out,
                    alu_add, z_in, zlo_out, pc_in, taken, branch_cnt, taken_cnt};

  branch_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .c2_in(c2_in), .con_q(con_q),
    .busy(busy), .done(done), .ir_c2(ir_c2), .gra(gra), .r_out(r_out),
    .con_enable(con_enable), .pc_out(pc_out), .y_in(y_in), .c_out(c_out),
    .alu_add(alu_add), .z_in(z_in), .zlo_out(zlo_out), .pc_in(pc_in),
    .taken(taken), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // condition flip-flop model: evaluates bus against ir_c2 on the rising edge of con_enable
  always @(posedge con_enable) begin
    #1;
    con_q = (ir_c2 == C2_ZERO)    ? (bus == 0) :
            (ir_c2 == C2_NONZERO) ? (bus != 0) :
            (ir_c2 == C2_POS)     ? !bus[31] : bus[31];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_branch(input logic [1:0] c2, input logic [31:0] b, input logic tk,
                            input logic [15:0] bc, input logic [15:0] tc);
    c2_in = c2;
    bus = b;
    start = 1;
    tick();
    start = 0;
    c2_in = ~c2;
    chk("t3_strobes", {busy, gra, r_out, con_enable, pc_out, done, pc_in}, 7'b1111000);
    chk("t3_ir_c2", ir_c2, c2);
    tick();
    chk("t4_strobes", {busy, con_enable, pc_out, y_in, c_out, pc_in}, 6'b101100);
    chk("t4_con_q", con_q, tk);
    tick();
    chk("t5_strobes", {busy, pc_out, c_out, alu_add, z_in, done, pc_in}, 7'b1011100);
    tick();
    chk("t6_strobes", {busy, z_in, zlo_out, done, pc_in}, {4'b1011, tk});
    chk("t6_ir_c2", ir_c2, c2);
    tick();
    chk("idle_strobes", {busy, done, zlo_out, pc_in}, 4'b0000);
    chk("taken", taken, tk);
    chk("branch_cnt", branch_cnt, bc);
    chk("taken_cnt", taken_cnt, tc);
  endtask

  initial begin
    int dones;
    logic [1:0] exp_c2;
    exp_c2 = '0;
    dones = 0;
    start = 1;
    tick();
    tick();
    chk("reset_with_start", all_out, 0);
    start = 0;
    clr_n = 1;
    repeat (10) tick();
    chk("idle_outputs", all_out, 0);

    run_branch(C2_ZERO, 32'h0, 1'b1, 16'd1, 16'd1);
    run_branch(C2_NEG, 32'h0000_0005, 1'b0, 16'd2, 16'd1);
    run_branch(C2_POS, 32'h0000_0007, 1'b1, 16'd3, 16'd2);

    // start held high: back-to-back branches with c2_in changing every cycle
    bus = 32'h8000_0000;
    c2_in = C2_POS;
    start = 1;
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) exp_c2 = c2_in;
      tick();
      chk("held_busy", busy, (i % 5) != 4);
      if (i % 5 != 4) chk("held_ir_c2", ir_c2, exp_c2);
      if (done) dones++;
      c2_in = c2_in + 2'd1;
    end
    start = 0;
    chk("held_done_count", dones, 4);
    chk("held_branch_cnt", branch_cnt, 16'd7);

    // reset in T5 aborts the branch
    c2_in = C2_ZERO;
    bus = 0;
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("in_t5", {c_out, z_in}, 2'b11);
    clr_n = 0;
    tick();
    chk("abort_outputs", all_out, 0);
    clr_n = 1;
    tick();
    chk("abort_after", all_out, 0);
    tick();
    chk("abort_after2", all_out, 0);

    // saturation
    force dut.u_branch_cnt.cnt = 16'hFFFF;
    force dut.u_taken_cnt.cnt = 16'hFFFF;
    #1;
    release dut.u_branch_cnt.cnt;
    release dut.u_taken_cnt.cnt;
    #1;
    chk("preload_branch_cnt", branch_cnt, 16'hFFFF);
    tick();
    run_branch(C2_ZERO, 32'h0, 1'b1, 16'hFFFF, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Control-side partner of the condition flip-flop.
- On a branch request it:
  - latches and drives the 2-bit condition code (IR_C2);
  - sequences the bus strobes that place Ra on the bus;
  - pulses the CON flip-flop enable;
  - forms PC+C in the ALU;
  - consumes the flip-flop's Q output to gate the PC load.
- Sits in the control unit between instruction decode and the datapath; it owns T3..T6 of branch instructions.

Parameters:
- CNT_W, 16, width of the branch and taken statistics counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  branch request from decode; sampled only in IDLE.
- c2_in  in  2  condition field of the current IR: 00 zero, 01 nonzero, 10 positive, 11 negative.
- con_q  in  1  Q output of the condition flip-flop.
- busy  out  1  high in T3..T6.
- done  out  1  one-cycle pulse in T6.
- ir_c2  out  2  latched condition code, driven to the condition flip-flop.
- gra  out  1  select Ra for register-out.
- r_out  out  1  register-file bus drive.
- con_enable  out  1  condition flip-flop capture strobe; the flip-flop captures on its rising edge.
- pc_out  out  1  PC bus drive.
- y_in  out  1  Y register load.
- c_out  out  1  sign-extended C bus drive.
- alu_add  out  1  ALU add select.
- z_in  out  1  Z register load.
- zlo_out  out  1  Zlow bus drive.
- pc_in  out  1  PC load; asserted only when the branch is taken.
- taken  out  1  result of the last completed branch.
- branch_cnt  out  CNT_W  completed branches, saturating.
- taken_cnt  out  CNT_W  taken branches, saturating.

Behaviour:
- Reset:
  - clr_n low at a rising edge forces state to IDLE.
  - It clears every output, including ir_c2=00, taken=0 and both counters.
  - This applies mid-sequence too: no further strobes, no PC load, counters untouched by the aborted branch.
- States (one-hot): IDLE, T3, T4, T5, T6.
  - IDLE -> T3 when start=1.
  - T3 -> T4 -> T5 -> T6 unconditionally.
  - T6 -> IDLE.
- start is ignored outside IDLE. A start held high across the end of a branch begins the next branch on the cycle after IDLE, so the minimum spacing is 5 cycles per branch.
- ir_c2 is loaded from c2_in on the IDLE->T3 edge and held until the next accepted start. Mid-branch changes on c2_in have no effect.
- All strobes are flops loaded from next-state decode, so they are glitch-free and aligned exactly with the state:
  - T3: gra, r_out, con_enable.
  - T4: pc_out, y_in.
  - T5: c_out, alu_add, z_in.
  - T6: zlo_out, pc_in (only if taken), done.
  - busy: all of T3..T6.
- con_enable:
  - High for exactly one cycle (T3), giving exactly one rising edge per branch.
  - con_q is valid from T4.
- Taken decision:
  - Sampled from con_q on the T5->T6 edge.
  - That sample sets the pc_in flop for T6.
  - The same value loads taken at the T6->IDLE edge.
  - taken holds until the next completed branch.
- Counters, updated on the T6->IDLE edge:
  - branch_cnt += 1.
  - taken_cnt += 1 if taken.
  - Both saturate at all-ones; no wrap.
- Simultaneous clr_n low and start=1: reset wins.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, T3..T6 one-hot);
  - condition-code constants (C2_ZERO=00, C2_NONZERO=01, C2_POS=10, C2_NEG=11), shared with the condition flip-flop and the decoder.
- One sub-module: sat_counter (CNT_W, synchronous active-low clear, increment enable), instantiated twice.

Test Plan:
- Reset then idle 10 cycles -> every output 0, busy=0, counters 0.
- start=1 one cycle with c2_in=00 and a condition-FF model fed bus=0 -> ir_c2=00; one con_enable pulse in T3; pc_in=1 and done=1 in T6; taken=1; branch_cnt=1, taken_cnt=1.
- c2_in=11 with bus=32'h0000_0005 -> con_q=0; pc_in stays 0 for the whole sequence; done=1 in T6; taken=0; branch_cnt=2, taken_cnt=1.
- start held high for 20 cycles -> exactly 4 branches, each 4 busy cycles separated by 1 IDLE cycle; c2_in toggled mid-branch leaves ir_c2 unchanged.
- clr_n low during T5 -> next cycle IDLE, all strobes 0, no pc_in, counters reset to 0.
- Counters preloaded via force to 16'hFFFF, then one taken branch -> both remain 16'hFFFF.
